// File: rtl/sigmoid_share_arbiter.sv
// ============================================================================
// Module   : sigmoid_share_arbiter
// Brief    : Round-robin front end sharing one fixed-latency sigmoid core
//            among N_REQ requesters, with tag-based result routing.
//            Optional alignment checker enabled by macro SIGMOID_ARB_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sigmoid_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 5,
  parameter int DATA_W  = 16,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_mask,
  output logic                    core_valid_in,
  output logic [DATA_W-1:0]       core_data_in,
  input  logic                    core_valid_out,
  input  logic [DATA_W-1:0]       core_data_out,
  output logic                    resp_valid,
  output logic [ID_W-1:0]         resp_id,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    busy,
  output logic                    err
);

  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   ptr_d;

  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  grant_oh;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  logic [DATA_W-1:0] grant_data;
  int                search_idx;

  logic              core_valid_in_q;
  logic [DATA_W-1:0] core_data_in_q;
  logic [ID_W-1:0]   issue_id_q;

  logic [LATENCY-1:0] tag_v_q;
  logic [ID_W-1:0]    tag_id_q [LATENCY];

  logic              resp_valid_q;
  logic [ID_W-1:0]   resp_id_q;
  logic [DATA_W-1:0] resp_data_q;

  assign eligible = req_valid & req_mask;

  // First eligible requester at or after ptr_q, wrapping around.
  always_comb begin
    grant_oh   = '0;
    grant_idx  = '0;
    grant_any  = 1'b0;
    grant_data = '0;
    search_idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      search_idx = int'(ptr_q) + k;
      if (search_idx >= N_REQ) begin
        search_idx = search_idx - N_REQ;
      end
      if (!grant_any && eligible[search_idx]) begin
        grant_any            = 1'b1;
        grant_idx            = ID_W'(search_idx);
        grant_oh[search_idx] = 1'b1;
        grant_data           = req_data[search_idx*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = rst ? '0 : grant_oh;

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      if (int'(grant_idx) == N_REQ - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q           <= '0;
      core_valid_in_q <= 1'b0;
      core_data_in_q  <= '0;
      issue_id_q      <= '0;
    end else begin
      ptr_q           <= ptr_d;
      core_valid_in_q <= grant_any;
      if (grant_any) begin
        core_data_in_q <= grant_data;
        issue_id_q     <= grant_idx;
      end
    end
  end

  // Tags are loaded from the issue register so that the last stage lines up
  // with the cycle the core presents its result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_q <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      tag_v_q[0]  <= core_valid_in_q;
      tag_id_q[0] <= issue_id_q;
      for (int s = 1; s < LATENCY; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end
    end
  end

  // A result without a live tag belongs to an operation discarded by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= core_valid_out & tag_v_q[LATENCY-1];
      if (core_valid_out && tag_v_q[LATENCY-1]) begin
        resp_id_q   <= tag_id_q[LATENCY-1];
        resp_data_q <= core_data_out;
      end
    end
  end

  assign core_valid_in = core_valid_in_q;
  assign core_data_in  = core_data_in_q;
  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_data     = resp_data_q;
  assign busy          = core_valid_in_q | (|tag_v_q);

`ifdef SIGMOID_ARB_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (core_valid_out != tag_v_q[LATENCY-1]) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sigmoid_share_arbiter.sv
// ============================================================================
// Module   : tb_sigmoid_share_arbiter
// Brief    : Self-checking bench for sigmoid_share_arbiter with a data+1 core stub.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sigmoid_share_arbiter;

  localparam int N   = 4;
  localparam int LAT = 5;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_mask  = '0;
  logic [N-1:0]  req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic          core_valid_in;
  logic [DW-1:0] core_data_in;
  logic          core_valid_out;
  logic [DW-1:0] core_data_out;
  logic          resp_valid;
  logic [1:0]    resp_id;
  logic [DW-1:0] resp_data;
  logic          busy;
  logic          err;
  logic          inject = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int ptr_m    = 0;

  typedef struct {
    int          due;
    int          id;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  sigmoid_share_arbiter #(.N_REQ(N), .LATENCY(LAT), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_mask(req_mask),
    .core_valid_in(core_valid_in), .core_data_in(core_data_in),
    .core_valid_out(core_valid_out), .core_data_out(core_data_out),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Core stub: fixed LAT-cycle delay, returns operand + 1; not reset.
  logic          sv [LAT];
  logic [DW-1:0] sd [LAT];
  initial begin
    for (int s = 0; s < LAT; s++) begin
      sv[s] = 1'b0;
      sd[s] = '0;
    end
  end
  always @(posedge clk) begin
    for (int s = LAT - 1; s > 0; s--) begin
      sv[s] <= sv[s-1];
      sd[s] <= sd[s-1];
    end
    sv[0] <= core_valid_in;
    sd[0] <= core_data_in;
  end
  assign core_valid_out = sv[LAT-1] | inject;
  assign core_data_out  = sd[LAT-1] + 16'd1;

  function automatic int model_pick(input logic [N-1:0] v, input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N] && m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ptr_m = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    req_valid = '1;
    req_mask  = '1;
    req_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    n_checks++; if (core_valid_in !== 1'b0) begin n_fail++; $display("FAIL reset_cvi: got %b expected 0", core_valid_in); end
    n_checks++; if (core_data_in !== 16'h0) begin n_fail++; $display("FAIL reset_cdi: got %h expected 0000", core_data_in); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    n_checks++; if (resp_id !== 2'd0) begin n_fail++; $display("FAIL reset_resp_id: got %0d expected 0", resp_id); end
    n_checks++; if (resp_data !== 16'h0) begin n_fail++; $display("FAIL reset_resp_data: got %h expected 0000", resp_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    repeat (2) begin @(posedge clk); #1; end
    req_mask = 4'hF;
    req_data = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0010};
    req_valid = 4'b0001;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++; if (busy !== (k >= 1 && k <= 6)) begin n_fail++; $display("FAIL single_busy[+%0d]: got %b expected %b", k, busy, (k >= 1 && k <= 6)); end
      n_checks++; if (resp_valid !== (k == 7)) begin n_fail++; $display("FAIL single_resp_valid[+%0d]: got %b expected %b", k, resp_valid, (k == 7)); end
      n_checks++; if (core_valid_in !== (k == 1)) begin n_fail++; $display("FAIL single_cvi[+%0d]: got %b expected %b", k, core_valid_in, (k == 1)); end
      if (k == 1) begin
        n_checks++; if (core_data_in !== 16'h0010) begin n_fail++; $display("FAIL single_cdi: got %h expected 0010", core_data_in); end
      end
      if (k >= 7) begin
        n_checks++; if (resp_data !== 16'h0011) begin n_fail++; $display("FAIL single_resp_data[+%0d]: got %h expected 0011", k, resp_data); end
      end
      if (k == 7) begin
        n_checks++; if (resp_id !== 2'd0) begin n_fail++; $display("FAIL single_resp_id: got %0d expected 0", resp_id); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] sent [12];
    int g;
    apply_reset();
    req_mask  = 4'hF;
    req_valid = 4'hF;
    req_data  = {$urandom, $urandom};
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k < 12) begin
        g = k % N;
        sent[k] = req_data[g*DW +: DW];
        n_checks++; if (req_ready !== (4'b0001 << g)) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, 4'b0001 << g); end
      end
      if (k >= 7 && k < 19) begin
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_resp_valid[%0d]: got %b expected 1", k, resp_valid); end
        n_checks++; if (resp_id !== 2'((k - 7) % N)) begin n_fail++; $display("FAIL rr_resp_id[%0d]: got %0d expected %0d", k, resp_id, (k - 7) % N); end
        n_checks++; if (resp_data !== sent[k-7] + 16'd1) begin n_fail++; $display("FAIL rr_resp_data[%0d]: got %h expected %h", k, resp_data, sent[k-7] + 16'd1); end
      end else begin
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_resp_idle[%0d]: got %b expected 0", k, resp_valid); end
      end
      @(posedge clk); #1;
      req_data = {$urandom, $urandom};
      if (k == 11) req_valid = '0;
    end
  endtask

  task automatic test_mask();
    apply_reset();
    req_valid = 4'b1010;
    req_mask  = 4'b0111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mask_ready[%0d]: got %b expected 0010", k, req_ready); end
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    req_mask  = 4'hF;
    req_valid = 4'b0111;
    req_data  = {$urandom, $urandom};
    repeat (3) begin @(posedge clk); #1; end
    req_valid = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_in_reset: got %b expected 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_resp[%0d]: got %b expected 0", k, resp_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy[%0d]: got %b expected 0", k, busy); end
      @(posedge clk); #1;
    end
    req_valid = 4'hF;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_ptr: got %b expected 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic test_random();
    int g;
    logic [N-1:0] exp_ready;
    logic exp_busy;
    apply_reset();
    for (int k = 0; k < 308; k++) begin
      if (k < 300) begin
        req_valid = N'($urandom);
        req_mask  = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'hF;
        req_data  = {$urandom, $urandom};
      end else begin
        req_valid = '0;
      end
      @(negedge clk);
      g = model_pick(req_valid, req_mask, ptr_m);
      exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", k, req_ready, exp_ready); end
      exp_busy = 1'b0;
      foreach (exp_q[j]) if (exp_q[j].due >= k + 1 && exp_q[j].due <= k + 6) exp_busy = 1'b1;
      n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rand_busy[%0d]: got %b expected %b", k, busy, exp_busy); end
      if (exp_q.size() > 0 && exp_q[0].due == k) begin
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL rand_resp_valid[%0d]: got %b expected 1", k, resp_valid); end
        n_checks++; if (resp_id !== 2'(exp_q[0].id)) begin n_fail++; $display("FAIL rand_resp_id[%0d]: got %0d expected %0d", k, resp_id, exp_q[0].id); end
        n_checks++; if (resp_data !== exp_q[0].data) begin n_fail++; $display("FAIL rand_resp_data[%0d]: got %h expected %h", k, resp_data, exp_q[0].data); end
        void'(exp_q.pop_front());
      end else begin
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rand_resp_idle[%0d]: got %b expected 0", k, resp_valid); end
      end
      if (g >= 0) begin
        exp_q.push_back('{k + 7, g, req_data[g*DW +: DW] + 16'd1});
        ptr_m = (g + 1) % N;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_err();
    apply_reset();
    repeat (8) begin @(posedge clk); #1; end
    @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_idle: got %b expected 0", err); end
    @(posedge clk); #1;
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
`ifdef SIGMOID_ARB_CHECK_EN
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky[%0d]: got %b expected 1", k, err); end
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL err_no_resp[%0d]: got %b expected 0", k, resp_valid); end
      @(posedge clk); #1;
    end
    apply_reset();
    @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b expected 0", err); end
    @(posedge clk); #1;
`else
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_const[%0d]: got %b expected 0", k, err); end
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL err_no_resp[%0d]: got %b expected 0", k, resp_valid); end
      @(posedge clk); #1;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mask();
    test_reset_mid_op();
    test_random();
    test_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/sigmoid_share_arbiter.md
SIGMOID_SHARE_ARBITER -- requirements
Module: sigmoid_share_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, 2..8.
REQ-002 Parameter LATENCY, default 5: fixed core latency in cycles, core_valid_in to core_valid_out.
REQ-003 Parameter DATA_W, default 16: operand/result width; ID_W = clog2(N_REQ).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  N_REQ  per-requester operand valid.
REQ-007 req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_data  in  N_REQ*DATA_W  operands; requester i uses bits [i*DATA_W +: DATA_W].
REQ-009 req_mask  in  N_REQ  1 = requester enabled for arbitration.
REQ-010 core_valid_in  out  1 / core_data_in  out  DATA_W  issue port to the shared sigmoid core.
REQ-011 core_valid_out  in  1 / core_data_out  in  DATA_W  result port from the core.
REQ-012 resp_valid  out  1 / resp_id  out  ID_W / resp_data  out  DATA_W  routed result, single-cycle pulse, no backpressure.
REQ-013 busy  out  1  any operation issued and not yet returned.
REQ-014 err  out  1  sticky result-alignment error (see Configuration).

Function
REQ-015 The arbiter SHALL be round-robin over eligible requesters (req_valid & req_mask); the search starts at index ptr, wrapping at N_REQ-1 -> 0.
REQ-016 req_ready SHALL be combinational, one-hot on the selected eligible requester, all-zero if none eligible.
REQ-017 A transfer SHALL occur when req_valid[i] & req_ready[i]; after a transfer to i, ptr SHALL become (i+1) mod N_REQ; with no transfer, ptr holds.
REQ-018 One transfer per cycle max; sustained throughput SHALL be one operation per cycle with no bubbles.
REQ-019 On a transfer in cycle t, core_valid_in=1 and core_data_in=req_data[i] SHALL be registered outputs in cycle t+1; otherwise core_valid_in=0 and core_data_in holds its last value.
REQ-020 A LATENCY-stage tag pipeline (valid bit + ID_W id) SHALL be loaded alongside core_valid_in so the tag reaches its last stage in the cycle core_valid_out is expected.
REQ-021 resp_valid, resp_data, resp_id SHALL be registered from core_valid_out, core_data_out and the last tag stage; total latency handshake -> resp_valid = LATENCY+2 cycles.
REQ-022 resp_data SHALL hold its last value when resp_valid=0; resp_id is defined only when resp_valid=1.
REQ-023 busy SHALL be the OR of the issue-register valid and all tag-stage valids.
REQ-024 Changing req_mask SHALL affect only arbitration from that cycle; in-flight operations complete and are routed normally.
REQ-025 A requester dropping req_valid with no transfer SHALL not move ptr.

Reset
REQ-026 While rst=1: ptr=0, core_valid_in=0, core_data_in=0, all tag valids 0, resp_valid=0, resp_id=0, resp_data=0, busy=0, err=0; req_ready all-zero.
REQ-027 Reset mid-operation SHALL discard all in-flight tags; no resp_valid SHALL be produced for operations issued before reset.

Configuration
REQ-028 Macro SIGMOID_ARB_CHECK_EN defined: err SHALL set when core_valid_out differs from the last tag-stage valid in any cycle, and clear only on rst.
REQ-029 Macro SIGMOID_ARB_CHECK_EN undefined: err SHALL be constant 0 and no checking logic SHALL be built; all other behaviour is identical.

Verification
REQ-030 Core replaced by a stub delaying data by LATENCY=5 and returning data+1; req 0 sends 16'h0010 at cycle 10 -> resp_valid at cycle 17, resp_id=0, resp_data=16'h0011, busy high cycles 11-16.
REQ-031 All four requesters valid continuously, mask 4'hF, from reset -> grant order 0,1,2,3,0,1,... one per cycle; resp_id stream identical order, 7 cycles later.
REQ-032 req_valid=4'b1010, mask=4'b0111 -> only requester 1 granted; requester 3 never sees req_ready.
REQ-033 Issue 3 operations, assert rst 2 cycles later for 1 cycle -> no resp_valid afterwards; busy=0, ptr=0 after reset.
REQ-034 With SIGMOID_ARB_CHECK_EN, stub injects spurious core_valid_out with no issue -> err=1 next cycle and stays 1 until rst; without macro err stays 0.
